traffic_light_monitor: RTL and testbench

Independent checker and lamp driver on the receiving end of the traffic-light controller's `state`/`timer` output pair. It samples the controller's 2-bit light state and down-counting phase timer once per strobe. It locks onto the phase sequence red → green → yellow → red and verifies every transition and every timer step against the configured phase times. It drives fail-safe one-hot lamp outputs, counts completed light cycles, and latches the first protocol violation with a cause code.

---
 rtl/traffic_light_monitor_if.sv | 28 ++
 rtl/traffic_light_monitor.sv | 150 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between the traffic-light controller's state/timer output and the monitor.
// The master side samples and clears; the monitor (slave) drives the lamps and status.
interface traffic_light_monitor_if #(
  parameter int TIMER_W = 4,
  parameter int CNT_W   = 16
);
  logic               sample_en;
  logic [1:0]         light_state;
  logic [TIMER_W-1:0] timer_in;
  logic               clear_err;
  logic               lamp_red;
  logic               lamp_yellow;
  logic               lamp_green;
  logic               locked;
  logic               err;
  logic [2:0]         err_code;
  logic [CNT_W-1:0]   cycle_count;

  modport master (
    output sample_en, light_state, timer_in, clear_err,
    input  lamp_red, lamp_yellow, lamp_green, locked, err, err_code, cycle_count
  );

  modport slave (
    input  sample_en, light_state, timer_in, clear_err,
    output lamp_red, lamp_yellow, lamp_green, locked, err, err_code, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Locks onto the red->green->yellow phase stream, checks every transition and timer step,
// drives fail-safe one-hot lamps, counts completed light cycles and latches the first fault.
module traffic_light_monitor #(
  parameter int TIMER_W     = 4,
  parameter int RED_TIME    = 10,
  parameter int GREEN_TIME  = 10,
  parameter int YELLOW_TIME = 5,
  parameter int CNT_W       = 16
) (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave bus
);

  localparam logic [1:0] ST_SYNC  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  localparam logic [1:0] L_RED     = 2'b00;
  localparam logic [1:0] L_YELLOW  = 2'b01;
  localparam logic [1:0] L_GREEN   = 2'b10;
  localparam logic [1:0] L_ILLEGAL = 2'b11;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_ENC   = 3'd1;
  localparam logic [2:0] E_TRANS = 3'd2;
  localparam logic [2:0] E_TIMER = 3'd3;

  localparam logic [2:0] LAMPS_RED = 3'b100;

  function automatic logic [TIMER_W-1:0] reload(input logic [1:0] s);
    case (s)
      L_GREEN:  reload = TIMER_W'(GREEN_TIME);
      L_YELLOW: reload = TIMER_W'(YELLOW_TIME);
      default:  reload = TIMER_W'(RED_TIME);
    endcase
  endfunction

  function automatic logic [1:0] succ(input logic [1:0] s);
    case (s)
      L_RED:    succ = L_GREEN;
      L_GREEN:  succ = L_YELLOW;
      default:  succ = L_RED;
    endcase
  endfunction

  // Lamps packed as {red, yellow, green}; anything unrecognised falls back to red.
  function automatic logic [2:0] decode(input logic [1:0] s);
    case (s)
      L_YELLOW: decode = 3'b010;
      L_GREEN:  decode = 3'b001;
      default:  decode = LAMPS_RED;
    endcase
  endfunction

  logic [1:0]         state_q, state_d;
  logic [1:0]         ps_q, ps_d;
  logic [TIMER_W-1:0] pt_q, pt_d;
  logic [2:0]         lamps_q, lamps_d;
  logic               err_q, err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         eff_state;
  logic [2:0]         fault;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    ps_d       = ps_q;
    pt_d       = pt_q;
    lamps_d    = lamps_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    eff_state  = state_q;
    fault      = E_NONE;

    // A clear applies first so a sample on the same edge is judged under SYNC rules.
    if (state_q == ST_FAULT && bus.clear_err) begin
      eff_state  = ST_SYNC;
      state_d    = ST_SYNC;
      err_d      = 1'b0;
      err_code_d = E_NONE;
      lamps_d    = decode(ps_q);
    end

    if (bus.sample_en && eff_state != ST_FAULT) begin
      ps_d = bus.light_state;
      pt_d = bus.timer_in;
      if (eff_state == ST_SYNC) begin
        lamps_d = decode(bus.light_state);
        if (bus.light_state != L_ILLEGAL && bus.timer_in == reload(bus.light_state))
          state_d = ST_TRACK;
      end else begin
        if (bus.light_state == L_ILLEGAL)
          fault = E_ENC;
        else if (pt_q != '0 && bus.light_state != ps_q)
          fault = E_TRANS;
        else if (pt_q == '0 && bus.light_state != succ(ps_q))
          fault = E_TRANS;
        else if (pt_q != '0 && bus.timer_in != pt_q - TIMER_W'(1))
          fault = E_TIMER;
        else if (pt_q == '0 && bus.timer_in != reload(bus.light_state))
          fault = E_TIMER;

        if (fault != E_NONE) begin
          state_d    = ST_FAULT;
          err_d      = 1'b1;
          err_code_d = fault;
          lamps_d    = LAMPS_RED;
        end else begin
          lamps_d = decode(bus.light_state);
          if (ps_q == L_YELLOW && bus.light_state == L_RED && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= ST_SYNC;
      ps_q       <= L_RED;
      pt_q       <= '0;
      lamps_q    <= LAMPS_RED;
      err_q      <= 1'b0;
      err_code_q <= E_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      pt_q       <= pt_d;
      lamps_q    <= lamps_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.lamp_red    = lamps_q[2];
  assign bus.lamp_yellow = lamps_q[1];
  assign bus.lamp_green  = lamps_q[0];
  assign bus.locked      = (state_q == ST_TRACK);
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: golden phase streams, a vector table of fault and
// clear cases, mid-stream reset, and counter saturation on a narrow-counter second instance.
module tb_traffic_light_monitor;

  localparam logic [1:0] RED = 2'b00, YEL = 2'b01, GRN = 2'b10, ILL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_light_monitor_if #(.TIMER_W(4), .CNT_W(16)) b1 ();
  traffic_light_monitor_if #(.TIMER_W(4), .CNT_W(2))  b2 ();

  traffic_light_monitor #(.TIMER_W(4), .RED_TIME(10), .GREEN_TIME(10), .YELLOW_TIME(5), .CNT_W(16))
    dut (.clk(clk), .rst(rst), .bus(b1));
  traffic_light_monitor #(.TIMER_W(4), .RED_TIME(10), .GREEN_TIME(10), .YELLOW_TIME(5), .CNT_W(2))
    dut_sat (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] ls;
    logic [3:0] t;
    logic [2:0] lamps;
    logic       locked;
    logic       err;
    logic [2:0] code;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [24];

  int errors = 0;
  int checks = 0;
  logic [1:0] gs, prev_s;
  logic [3:0] gt;
  int exp_cnt;

  function automatic logic [3:0] reload_m(input logic [1:0] s);
    if (s == GRN) return 4'd10;
    if (s == YEL) return 4'd5;
    return 4'd10;
  endfunction

  function automatic logic [1:0] succ_m(input logic [1:0] s);
    if (s == RED) return GRN;
    if (s == GRN) return YEL;
    return RED;
  endfunction

  function automatic logic [2:0] lamp_m(input logic [1:0] s);
    if (s == YEL) return 3'b010;
    if (s == GRN) return 3'b001;
    return 3'b100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] lamps1();
    return {b1.lamp_red, b1.lamp_yellow, b1.lamp_green};
  endfunction

  task automatic drive(input logic en, input logic clr, input logic [1:0] ls, input logic [3:0] t);
    @(negedge clk);
    b1.sample_en = en;  b1.clear_err = clr;  b1.light_state = ls;  b1.timer_in = t;
    b2.sample_en = en;  b2.clear_err = clr;  b2.light_state = ls;  b2.timer_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    b1.sample_en = 1'b0;  b1.clear_err = 1'b0;
    b2.sample_en = 1'b0;  b2.clear_err = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    prev_s  = RED;
  endtask

  task automatic adv();
    if (gt != 4'd0) gt = gt - 4'd1;
    else begin
      gs = succ_m(gs);
      gt = reload_m(gs);
    end
  endtask

  // Golden samples starting at (gs, gt); the bench counts yellow->red steps itself.
  task automatic feed_golden(input int n, input logic chk_lock);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, gs, gt);
      if (prev_s == YEL && gs == RED) exp_cnt++;
      prev_s = gs;
      check("golden_lamps", 32'(lamps1()), 32'(lamp_m(gs)));
      if (chk_lock) begin
        check("golden_locked", 32'(b1.locked), 32'd1);
        check("golden_cnt", 32'(b1.cycle_count), 32'(exp_cnt));
      end
      adv();
    end
  endtask

  initial begin
    b1.sample_en = 1'b0;  b1.clear_err = 1'b0;  b1.light_state = RED;  b1.timer_in = 4'd0;
    b2.sample_en = 1'b0;  b2.clear_err = 1'b0;  b2.light_state = RED;  b2.timer_in = 4'd0;

    //            en    clr   ls   t      lamps   lk    err   code  cnt
    tbl[0]  = '{1'b1, 1'b0, RED, 4'd10, 3'b100, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, RED, 4'd9,  3'b100, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, RED, 4'd8,  3'b100, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, RED, 4'd6,  3'b100, 1'b0, 1'b1, 3'd3, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, RED, 4'd5,  3'b100, 1'b0, 1'b1, 3'd3, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, GRN, 4'd10, 3'b001, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, GRN, 4'd9,  3'b001, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[7]  = '{1'b0, 1'b1, YEL, 4'd3,  3'b001, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[8]  = '{1'b1, 1'b1, GRN, 4'd8,  3'b001, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, ILL, 4'd7,  3'b100, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[10] = '{1'b0, 1'b0, GRN, 4'd2,  3'b100, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[11] = '{1'b0, 1'b0, YEL, 4'd5,  3'b100, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[12] = '{1'b0, 1'b0, RED, 4'd10, 3'b100, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[13] = '{1'b0, 1'b0, ILL, 4'd15, 3'b100, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[14] = '{1'b0, 1'b0, GRN, 4'd10, 3'b100, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[15] = '{1'b1, 1'b0, YEL, 4'd4,  3'b100, 1'b0, 1'b1, 3'd1, 16'd0};
    tbl[16] = '{1'b1, 1'b1, YEL, 4'd5,  3'b010, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[17] = '{1'b1, 1'b0, YEL, 4'd4,  3'b010, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[18] = '{1'b1, 1'b0, YEL, 4'd3,  3'b010, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[19] = '{1'b1, 1'b0, YEL, 4'd2,  3'b010, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[20] = '{1'b1, 1'b0, YEL, 4'd1,  3'b010, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[21] = '{1'b1, 1'b0, YEL, 4'd0,  3'b010, 1'b1, 1'b0, 3'd0, 16'd0};
    tbl[22] = '{1'b1, 1'b0, RED, 4'd10, 3'b100, 1'b1, 1'b0, 3'd0, 16'd1};
    tbl[23] = '{1'b1, 1'b0, GRN, 4'd9,  3'b100, 1'b0, 1'b1, 3'd2, 16'd1};

    // Reset values.
    do_reset();
    check("rst_lamps", 32'(lamps1()), 32'b100);
    check("rst_locked", 32'(b1.locked), 32'd0);
    check("rst_err", 32'(b1.err), 32'd0);
    check("rst_code", 32'(b1.err_code), 32'd0);
    check("rst_cnt", 32'(b1.cycle_count), 32'd0);

    // Three full light cycles plus the closing red sample.
    gs = RED;  gt = 4'd10;
    feed_golden(85, 1'b1);
    check("golden_cnt3", 32'(b1.cycle_count), 32'd3);
    check("golden_err", 32'(b1.err), 32'd0);

    // Mid-phase start: no lock until the next phase-start sample.
    do_reset();
    gs = GRN;  gt = 4'd7;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, gs, gt);
      check("sync_lamps", 32'(lamps1()), 32'b001);
      check("sync_locked", 32'(b1.locked), 32'd0);
      adv();
    end
    drive(1'b1, 1'b0, gs, gt);
    check("sync_lock_lamps", 32'(lamps1()), 32'b010);
    check("sync_lock_locked", 32'(b1.locked), 32'd1);

    // Illegal transition after (green,0), then a later timer error must not overwrite the code.
    do_reset();
    gs = RED;  gt = 4'd10;
    feed_golden(22, 1'b1);
    drive(1'b1, 1'b0, RED, 4'd10);
    check("trans_err", 32'(b1.err), 32'd1);
    check("trans_code", 32'(b1.err_code), 32'd2);
    check("trans_locked", 32'(b1.locked), 32'd0);
    check("trans_lamps", 32'(lamps1()), 32'b100);
    drive(1'b1, 1'b0, RED, 4'd3);
    check("trans_code_kept", 32'(b1.err_code), 32'd2);
    drive(1'b1, 1'b1, RED, 4'd10);
    check("trans_clr_locked", 32'(b1.locked), 32'd1);
    check("trans_clr_err", 32'(b1.err), 32'd0);

    // Vector table: timer error, clear+lock, illegal encoding, hold, counting.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].ls, tbl[i].t);
      check($sformatf("vec%0d_lamps", i), 32'(lamps1()), 32'(tbl[i].lamps));
      check($sformatf("vec%0d_locked", i), 32'(b1.locked), 32'(tbl[i].locked));
      check($sformatf("vec%0d_err", i), 32'(b1.err), 32'(tbl[i].err));
      check($sformatf("vec%0d_code", i), 32'(b1.err_code), 32'(tbl[i].code));
      check($sformatf("vec%0d_cnt", i), 32'(b1.cycle_count), 32'(tbl[i].cnt));
    end

    // Reset mid-green overrides an active sample.
    do_reset();
    gs = RED;  gt = 4'd10;
    feed_golden(70, 1'b1);
    check("mid_cnt2", 32'(b1.cycle_count), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    b1.sample_en = 1'b1;  b1.light_state = GRN;  b1.timer_in = 4'd7;
    b2.sample_en = 1'b1;  b2.light_state = GRN;  b2.timer_in = 4'd7;
    @(posedge clk);
    #1;
    check("midrst_lamps", 32'(lamps1()), 32'b100);
    check("midrst_locked", 32'(b1.locked), 32'd0);
    check("midrst_err", 32'(b1.err), 32'd0);
    check("midrst_cnt", 32'(b1.cycle_count), 32'd0);

    // Five cycles: wide counter reaches 5, the 2-bit counter sticks at 3.
    do_reset();
    gs = RED;  gt = 4'd10;
    feed_golden(141, 1'b1);
    check("sat_wide_cnt", 32'(b1.cycle_count), 32'd5);
    check("sat_narrow_cnt", 32'(b2.cycle_count), 32'd3);
    check("sat_narrow_locked", 32'(b2.locked), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
